// File: rtl/melody_sequencer.sv
// Melody sequencer: forwards the manual keypad while idle and plays a fixed 16-entry ROM melody on start.
// Optional build macro MELODY_LOOP_EN makes playback repeat from entry 0 until stop or reset.
module melody_sequencer #(
    parameter int BEAT_CYCLES = 250000,
    parameter int GAP_CYCLES  = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] key_in,
    output logic [7:0] key_out,
    output logic       busy,
    output logic [3:0] note_idx,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_NOTE = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [20:0] BEAT_W   = 21'(BEAT_CYCLES);
    localparam logic [20:0] GAP_LAST = 21'(GAP_CYCLES - 1);

    // Entry format: [7] end, [6] rest, [5:3] note, [2:0] duration code.
    function automatic logic [7:0] rom_entry(input logic [3:0] idx);
        logic [7:0] ent;
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd4, 4'd5, 4'd6, 4'd7: ent = {2'b00, idx[2:0], 3'b000};
            4'd8:                   ent = 8'b0100_0001;
            4'd9:                   ent = 8'b1000_0011;
            default:                ent = 8'b1000_0000;
        endcase
        return ent;
    endfunction

    // Counter preset so that the note phase lasts (d+1) beats when counting down to zero.
    function automatic logic [20:0] dur_last(input logic [2:0] d);
        logic [20:0] beats;
        beats = {18'd0, d} + 21'd1;
        return (beats * BEAT_W) - 21'd1;
    endfunction

    function automatic logic [7:0] note_key(input logic [7:0] ent);
        logic [7:0] top;
        top = 8'b1000_0000;
        return ent[6] ? 8'h00 : (top >> ent[5:3]);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [20:0] cnt_q, cnt_d;
    logic [7:0]  nkey_q, nkey_d;
    logic        end_q, end_d;
    logic [7:0]  key_out_q, key_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  rom_s;
    logic        key_onehot_s;

    assign rom_s        = rom_entry(idx_q);
    assign key_onehot_s = (key_in != 8'h00) && ((key_in & (key_in - 8'd1)) == 8'h00);

    // Next-state and next-output logic for the playback FSM.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        nkey_d    = nkey_q;
        end_d     = end_q;
        key_out_d = 8'h00;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idx_d = 4'd0;
                cnt_d = 21'd0;
                if (start && !stop) begin
                    state_d = ST_LOAD;
                end else if (key_onehot_s) begin
                    key_out_d = key_in;
                end else begin
                    key_out_d = 8'h00;
                end
            end
            ST_LOAD: begin
                nkey_d    = note_key(rom_s);
                end_d     = rom_s[7];
                cnt_d     = dur_last(rom_s[2:0]);
                key_out_d = note_key(rom_s);
                state_d   = ST_NOTE;
            end
            ST_NOTE: begin
                if (cnt_q == 21'd0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LAST;
                end else begin
                    cnt_d     = cnt_q - 21'd1;
                    key_out_d = nkey_q;
                end
            end
            ST_GAP: begin
                if (cnt_q != 21'd0) begin
                    cnt_d = cnt_q - 21'd1;
                end else if (end_q || (idx_q == 4'd15)) begin
                    done_d = 1'b1;
                    idx_d  = 4'd0;
`ifdef MELODY_LOOP_EN
                    state_d = ST_LOAD;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
                cnt_d   = 21'd0;
            end
        endcase

        // Abort overrides everything the active phase decided.
        if (stop && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            idx_d     = 4'd0;
            cnt_d     = 21'd0;
            key_out_d = 8'h00;
            done_d    = 1'b0;
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            cnt_q     <= 21'd0;
            nkey_q    <= 8'h00;
            end_q     <= 1'b0;
            key_out_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            nkey_q    <= nkey_d;
            end_q     <= end_d;
            key_out_q <= key_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign key_out  = key_out_q;
    assign busy     = busy_q;
    assign note_idx = idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomized scoreboard bench for melody_sequencer; the model derives outputs from the melody timeline.
module tb_melody_sequencer;

    localparam int B = 10;
    localparam int G = 2;
`ifdef MELODY_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, stop;
    logic [7:0] key_in;
    logic [7:0] key_out;
    logic       busy;
    logic [3:0] note_idx;
    logic       done;

    typedef struct packed {
        logic [7:0] key;
        logic       busy;
        logic [3:0] idx;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   playing = 1'b0;
    int   offset = 0;

    always #5 clk = ~clk;

    melody_sequencer #(.BEAT_CYCLES(B), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .key_in(key_in),
        .key_out(key_out), .busy(busy), .note_idx(note_idx), .done(done)
    );

    function automatic logic [7:0] rom_model(input int i);
        logic [2:0] n;
        n = 3'(i);
        if (i < 8) return {2'b00, n, 3'b000};
        else if (i == 8) return 8'h41;
        else if (i == 9) return 8'h83;
        else return 8'h80;
    endfunction

    function automatic int entry_len(input int i);
        logic [7:0] ent;
        ent = rom_model(i);
        return 1 + (int'(ent[2:0]) + 1) * B + G;
    endfunction

    function automatic int melody_len();
        int total = 0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] ent;
            ent = rom_model(i);
            total += entry_len(i);
            if (ent[7] || i == 15) break;
        end
        return total;
    endfunction

    // Outputs at offset o cycles after the first LOAD cycle, within one pass.
    function automatic exp_t timeline(input int o);
        exp_t e;
        int pos = 0;
        logic [7:0] top;
        top = 8'h80;
        e = '0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] ent;
            int dur, rel;
            ent = rom_model(i);
            dur = (int'(ent[2:0]) + 1) * B;
            if (o < pos + entry_len(i)) begin
                rel    = o - pos;
                e.busy = 1'b1;
                e.idx  = 4'(i);
                e.key  = (rel >= 1 && rel <= dur && !ent[6]) ? (top >> ent[5:3]) : 8'h00;
                return e;
            end
            pos += entry_len(i);
        end
        return e;
    endfunction

    function automatic logic [7:0] rand_key();
        logic [7:0] one;
        one = 8'h01;
        if ($urandom_range(1, 0) == 1) return one << $urandom_range(7, 0);
        else return 8'($urandom);
    endfunction

    // Drive one cycle of inputs and queue the response expected after the next edge.
    task automatic step(input logic r, input logic s, input logic p, input logic [7:0] k);
        exp_t e;
        int   total;
        @(negedge clk);
        reset  = r;
        start  = s;
        stop   = p;
        key_in = k;
        total  = melody_len();
        e      = '0;
        if (r) begin
            playing = 1'b0;
        end else if (playing && p) begin
            playing = 1'b0;
        end else if (playing) begin
            offset++;
            if (!LOOP && offset == total) begin
                e.done  = 1'b1;
                playing = 1'b0;
            end else begin
                e      = timeline(offset % total);
                e.done = (offset % total == 0);
            end
        end else if (s && !p) begin
            playing = 1'b1;
            offset  = 0;
            e.busy  = 1'b1;
        end else begin
            e.key = ($countones(k) == 1) ? k : 8'h00;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a fresh registered output set.
    always @(posedge clk) begin
        exp_t e, act;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = '{key: key_out, busy: busy, idx: note_idx, done: done};
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                if (n_bad <= 20)
                    $display("FAIL outputs t=%0t: got key=%h busy=%b idx=%0d done=%b, expected key=%h busy=%b idx=%0d done=%b",
                             $time, act.key, act.busy, act.idx, act.done, e.key, e.busy, e.idx, e.done);
            end
        end
    end

    initial begin
        int n_play;
        reset = 1'b1; start = 1'b0; stop = 1'b0; key_in = 8'h00;
        repeat (3) step(1'b1, 1'b0, 1'b0, rand_key());

        // Manual pass-through
        step(1'b0, 1'b0, 1'b0, 8'h04);
        step(1'b0, 1'b0, 1'b0, 8'h05);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (20) step(1'b0, 1'b0, 1'b0, rand_key());

        // Full melody with an ignored start re-pulse; loop mode runs into the second pass
        n_play = LOOP ? 345 : 175;
        step(1'b0, 1'b1, 1'b0, rand_key());
        for (int c = 1; c <= n_play; c++) step(1'b0, (c == 49), 1'b0, rand_key());
        step(1'b0, 1'b0, LOOP, rand_key());
        repeat (3) step(1'b0, 1'b0, 1'b0, rand_key());

        // start and stop together in IDLE
        step(1'b0, 1'b1, 1'b1, rand_key());
        repeat (3) step(1'b0, 1'b0, 1'b0, rand_key());

        // Stop mid-note
        step(1'b0, 1'b1, 1'b0, rand_key());
        for (int c = 1; c < 20; c++) step(1'b0, 1'b0, 1'b0, rand_key());
        step(1'b0, 1'b0, 1'b1, rand_key());
        repeat (4) step(1'b0, 1'b0, 1'b0, rand_key());

        // Reset mid-play, then replay from entry 0
        step(1'b0, 1'b1, 1'b0, rand_key());
        for (int c = 1; c < 100; c++) step(1'b0, 1'b0, 1'b0, rand_key());
        step(1'b1, 1'b0, 1'b0, rand_key());
        step(1'b0, 1'b1, 1'b0, rand_key());
        repeat (30) step(1'b0, 1'b0, 1'b0, rand_key());
        step(1'b0, 1'b0, 1'b1, rand_key());

        // Random traffic
        for (int c = 0; c < 3000; c++)
            step(($urandom % 800) == 0, ($urandom % 40) == 0, ($urandom % 250) == 0, rand_key());

        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
